// File: rtl/pw_trigger_sequencer_pkg.sv
// Shared types for the pattern matcher / trigger sequencer pair.
package pw_trigger_sequencer_pkg;

   typedef enum logic [2:0] {
      TsIdle      = 3'd0,
      TsWaitMatch = 3'd1,
      TsDelay     = 3'd2,
      TsPulse     = 3'd3,
      TsDone      = 3'd4
   } ts_state_e;

   typedef enum logic {
      PmCapture = 1'b0,
      PmTrigger = 1'b1
   } pm_action_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pw_trigger_sequencer.sv
// Armed trigger pulse-train generator: after a match edge, emits up to pNUM_TRIGGERS
// pulses with per-pulse delay and width, then a one-cycle completion strobe.
module pw_trigger_sequencer
   import pw_trigger_sequencer_pkg::*;
#(
   parameter int unsigned pNUM_TRIGGERS = 8,
   parameter int unsigned pDELAY_WIDTH  = 20,
   parameter int unsigned pWIDTH_WIDTH  = 17
) (
   input  logic                                    trigger_clk,
   input  logic                                    reset_i,
   input  logic                                    I_arm,
   input  logic                                    I_match,
   input  logic [$clog2(pNUM_TRIGGERS+1)-1:0]      I_num_triggers,
   input  logic [pNUM_TRIGGERS*pDELAY_WIDTH-1:0]   I_delays,
   input  logic [pNUM_TRIGGERS*pWIDTH_WIDTH-1:0]   I_widths,
   output logic                                    O_trigger,
   output logic                                    O_trigger_pulse,
   output logic                                    O_busy,
   output logic                                    O_done
);

   localparam int unsigned IW = (pNUM_TRIGGERS > 1) ? $clog2(pNUM_TRIGGERS) : 1;
   localparam int unsigned CW = max_u(pDELAY_WIDTH, pWIDTH_WIDTH);

   ts_state_e                r_state;
   logic [CW-1:0]            r_count;
   logic [IW-1:0]            r_index;
   logic [IW-1:0]            r_last;
   logic [pWIDTH_WIDTH-1:0]  r_width0;
   logic                     r_arm;
   logic                     r_match;
   logic                     r_trigger;
   logic                     r_trig_pulse;
   logic                     r_busy;
   logic                     r_done;

   logic                     w_arm_rise;
   logic                     w_arm_fall;
   logic                     w_match_rise;
   logic [IW-1:0]            w_last;
   logic [IW-1:0]            w_next_idx;
   logic [pDELAY_WIDTH-1:0]  w_dly_next;
   logic [pWIDTH_WIDTH-1:0]  w_wid_cur;
   logic [pWIDTH_WIDTH-1:0]  w_wid_next;
   logic [CW-1:0]            w_wid_cur_load;
   logic [CW-1:0]            w_wid_next_load;
   logic [CW-1:0]            w_dly_next_load;

   assign w_arm_rise   = I_arm & ~r_arm;
   assign w_arm_fall   = ~I_arm & r_arm;
   assign w_match_rise = I_match & ~r_match;

   // 0 pulses is treated as 1; anything above the maximum is clamped.
   always_comb begin
      w_last = '0;
      if (I_num_triggers == '0) begin
         w_last = '0;
      end else if (32'(I_num_triggers) > pNUM_TRIGGERS) begin
         w_last = IW'(pNUM_TRIGGERS - 1);
      end else begin
         w_last = IW'(I_num_triggers - 1'b1);
      end
   end

   always_comb begin
      w_next_idx      = r_index + 1'b1;
      w_dly_next      = I_delays[32'(w_next_idx)*pDELAY_WIDTH +: pDELAY_WIDTH];
      w_wid_next      = I_widths[32'(w_next_idx)*pWIDTH_WIDTH +: pWIDTH_WIDTH];
      w_wid_cur       = (r_index == '0) ? r_width0
                                        : I_widths[32'(r_index)*pWIDTH_WIDTH +: pWIDTH_WIDTH];
      w_wid_cur_load  = (w_wid_cur == '0) ? '0 : CW'(w_wid_cur - 1'b1);
      w_wid_next_load = (w_wid_next == '0) ? '0 : CW'(w_wid_next - 1'b1);
      // Inter-pulse gaps are entered from PULSE, which already spent one low cycle.
      w_dly_next_load = (w_dly_next == '0) ? '0 : CW'(w_dly_next - 1'b1);
   end

   always_ff @(posedge trigger_clk) begin
      if (reset_i) begin
         r_state      <= TsIdle;
         r_count      <= '0;
         r_index      <= '0;
         r_last       <= '0;
         r_width0     <= '0;
         r_arm        <= 1'b0;
         r_match      <= 1'b0;
         r_trigger    <= 1'b0;
         r_trig_pulse <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_arm        <= I_arm;
         r_match      <= I_match;
         r_trig_pulse <= 1'b0;
         if (w_arm_fall) begin
            r_state   <= TsIdle;
            r_count   <= '0;
            r_index   <= '0;
            r_trigger <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
         end else begin
            unique case (r_state)
               TsIdle: begin
                  if (w_arm_rise) r_state <= TsWaitMatch;
               end
               TsWaitMatch: begin
                  if (w_match_rise) begin
                     r_state  <= TsDelay;
                     r_index  <= '0;
                     r_count  <= CW'(I_delays[pDELAY_WIDTH-1:0]);
                     r_last   <= w_last;
                     r_width0 <= I_widths[pWIDTH_WIDTH-1:0];
                     r_busy   <= 1'b1;
                  end
               end
               TsDelay: begin
                  if (r_count == '0) begin
                     r_state   <= TsPulse;
                     r_count   <= w_wid_cur_load;
                     r_trigger <= 1'b1;
                  end else begin
                     r_count <= r_count - 1'b1;
                  end
               end
               TsPulse: begin
                  if (r_count != '0) begin
                     r_count <= r_count - 1'b1;
                  end else if (r_index == r_last) begin
                     r_state      <= TsDone;
                     r_trigger    <= 1'b0;
                     r_busy       <= 1'b0;
                     r_done       <= 1'b1;
                     r_trig_pulse <= 1'b1;
                  end else begin
                     r_index <= w_next_idx;
                     // A zero gap merges the next pulse into this one.
                     if (w_dly_next == '0) begin
                        r_count <= w_wid_next_load;
                     end else begin
                        r_state   <= TsDelay;
                        r_count   <= w_dly_next_load;
                        r_trigger <= 1'b0;
                     end
                  end
               end
               TsDone: begin
                  if (!I_arm) begin
                     r_state <= TsIdle;
                     r_done  <= 1'b0;
                  end
               end
               default: begin
                  r_state   <= TsIdle;
                  r_trigger <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign O_trigger       = r_trigger;
   assign O_trigger_pulse = r_trig_pulse;
   assign O_busy          = r_busy;
   assign O_done          = r_done;

endmodule

// File: tb/tb_pw_trigger_sequencer.sv
// Scoreboarded bench: expected trigger intervals and strobes are queued by the stimulus,
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_pw_trigger_sequencer;

   localparam int N  = 8;
   localparam int DW = 20;
   localparam int WW = 17;
   localparam int NW = $clog2(N + 1);

   logic              trigger_clk = 1'b0;
   logic              reset_i = 1'b1;
   logic              I_arm = 1'b0;
   logic              I_match = 1'b0;
   logic [NW-1:0]     I_num_triggers = '0;
   logic [N*DW-1:0]   I_delays = '0;
   logic [N*WW-1:0]   I_widths = '0;
   logic              O_trigger;
   logic              O_trigger_pulse;
   logic              O_busy;
   logic              O_done;

   pw_trigger_sequencer #(
      .pNUM_TRIGGERS(N),
      .pDELAY_WIDTH (DW),
      .pWIDTH_WIDTH (WW)
   ) dut (
      .trigger_clk    (trigger_clk),
      .reset_i        (reset_i),
      .I_arm          (I_arm),
      .I_match        (I_match),
      .I_num_triggers (I_num_triggers),
      .I_delays       (I_delays),
      .I_widths       (I_widths),
      .O_trigger      (O_trigger),
      .O_trigger_pulse(O_trigger_pulse),
      .O_busy         (O_busy),
      .O_done         (O_done)
   );

   always #5 trigger_clk = ~trigger_clk;

   int cyc = 0;
   always @(posedge trigger_clk) cyc <= cyc + 1;

   typedef struct {
      bit strobe;
      int at;
      int len;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   dv[8];
   int   wv[8];

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_pulse(input int at, input int len);
      exp_t e;
      e.strobe = 1'b0; e.at = at; e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic push_strobe(input int at);
      exp_t e;
      e.strobe = 1'b1; e.at = at; e.len = 0;
      exp_q.push_back(e);
   endtask

   task automatic sb_check(input bit strobe, input int at, input int len);
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_%s: got at=%0d len=%0d, expected nothing",
                  strobe ? "strobe" : "pulse", at, len);
      end else begin
         e = exp_q.pop_front();
         if (e.strobe != strobe || e.at != at || e.len != len) begin
            bad++;
            $display("FAIL sb_event: got strobe=%0d at=%0d len=%0d, expected strobe=%0d at=%0d len=%0d",
                     strobe, at, len, e.strobe, e.at, e.len);
         end
      end
   endtask

   task automatic drain(input string name);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_missing: got %0d events outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: reconstruct O_trigger high intervals and completion strobes.
   logic prev_trig = 1'b0;
   int   t_start = 0;
   always @(negedge trigger_clk) begin
      if (reset_i) begin
         prev_trig <= 1'b0;
      end else begin
         if (O_trigger && !prev_trig) t_start <= cyc;
         if (!O_trigger && prev_trig) sb_check(1'b0, t_start, cyc - t_start);
         if (O_trigger_pulse) begin
            sb_check(1'b1, cyc, 0);
            chk("done_with_strobe", int'(O_done), 1);
         end
         prev_trig <= O_trigger;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge trigger_clk);
   endtask

   task automatic set_cfg(input int num);
      I_num_triggers = NW'(num);
      for (int i = 0; i < N; i++) begin
         I_delays[i*DW +: DW] = DW'(dv[i]);
         I_widths[i*WW +: WW] = WW'(wv[i]);
      end
   endtask

   task automatic arm_up();
      I_arm = 1'b0;
      I_match = 1'b0;
      step(2);
      I_arm = 1'b1;
      step(2);
   endtask

   // The edge sampling the new match level becomes cycle m.
   task automatic fire_match(output int m);
      I_match = 1'b1;
      m = cyc + 1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int m;

      // Reset with arm and match held high.
      dv = '{0, 0, 0, 0, 0, 0, 0, 0};
      wv = '{1, 0, 0, 0, 0, 0, 0, 0};
      set_cfg(1);
      reset_i = 1'b1; I_arm = 1'b1; I_match = 1'b1;
      step(3);
      chk("rst_trigger", int'(O_trigger), 0);
      chk("rst_strobe",  int'(O_trigger_pulse), 0);
      chk("rst_busy",    int'(O_busy), 0);
      chk("rst_done",    int'(O_done), 0);
      reset_i = 1'b0;
      step(6);
      chk("held_match_trigger", int'(O_trigger), 0);
      chk("held_match_busy",    int'(O_busy), 0);
      arm_up();
      fire_match(m);
      push_pulse(m + 1, 1);
      push_strobe(m + 2);
      step(8);
      drain("t1");
      chk("t1_done_held", int'(O_done), 1);
      I_arm = 1'b0;
      step(2);
      chk("t1_done_clear", int'(O_done), 0);

      // N=1, D0=3, W0=2.
      dv = '{3, 0, 0, 0, 0, 0, 0, 0};
      wv = '{2, 0, 0, 0, 0, 0, 0, 0};
      set_cfg(1);
      arm_up();
      fire_match(m);
      push_pulse(m + 4, 2);
      push_strobe(m + 6);
      step(3);
      chk("t2_busy", int'(O_busy), 1);
      step(8);
      drain("t2");
      chk("t2_busy_after", int'(O_busy), 0);

      // N=3, D={0,2,0}, W={1,3,2}: last two pulses merge.
      dv = '{0, 2, 0, 0, 0, 0, 0, 0};
      wv = '{1, 3, 2, 0, 0, 0, 0, 0};
      set_cfg(3);
      arm_up();
      fire_match(m);
      push_pulse(m + 1, 1);
      push_pulse(m + 4, 5);
      push_strobe(m + 9);
      step(14);
      drain("t3");

      // N=0 behaves as one pulse; W=0 gives a 1-cycle pulse.
      dv = '{1, 5, 5, 5, 5, 5, 5, 5};
      wv = '{0, 3, 3, 3, 3, 3, 3, 3};
      set_cfg(0);
      arm_up();
      fire_match(m);
      push_pulse(m + 2, 1);
      push_strobe(m + 3);
      step(14);
      drain("t4a");

      // N=15 is clamped to 8 pulses.
      dv = '{0, 1, 1, 1, 1, 1, 1, 1};
      wv = '{0, 0, 0, 0, 0, 0, 0, 0};
      set_cfg(15);
      arm_up();
      fire_match(m);
      for (int i = 0; i < 8; i++) push_pulse(m + 1 + 2 * i, 1);
      push_strobe(m + 16);
      step(22);
      drain("t4b");

      // Abort during the second pulse, then a full re-run.
      dv = '{1, 1, 1, 0, 0, 0, 0, 0};
      wv = '{2, 4, 2, 0, 0, 0, 0, 0};
      set_cfg(3);
      arm_up();
      fire_match(m);
      push_pulse(m + 2, 2);
      push_pulse(m + 5, 1);
      step(6);
      I_arm = 1'b0;
      step(1);
      chk("abort_trigger", int'(O_trigger), 0);
      chk("abort_busy",    int'(O_busy), 0);
      chk("abort_done",    int'(O_done), 0);
      step(6);
      drain("t5_abort");
      arm_up();
      fire_match(m);
      push_pulse(m + 2, 2);
      push_pulse(m + 5, 4);
      push_pulse(m + 10, 2);
      push_strobe(m + 12);
      step(18);
      drain("t5_rerun");

      // Extra match edges in DELAY and DONE are ignored.
      dv = '{4, 0, 0, 0, 0, 0, 0, 0};
      wv = '{1, 0, 0, 0, 0, 0, 0, 0};
      set_cfg(1);
      arm_up();
      fire_match(m);
      push_pulse(m + 5, 1);
      push_strobe(m + 6);
      step(1);
      I_match = 1'b0;
      step(1);
      I_match = 1'b1;
      step(6);
      I_match = 1'b0;
      step(1);
      I_match = 1'b1;
      step(8);
      chk("t6_done", int'(O_done), 1);
      chk("t6_busy", int'(O_busy), 0);
      drain("t6");
      I_arm = 1'b0;
      I_match = 1'b0;
      step(2);
      chk("t6_done_clear", int'(O_done), 0);

      // Reset mid-pulse: outputs clear, no strobe.
      dv = '{2, 0, 0, 0, 0, 0, 0, 0};
      wv = '{5, 0, 0, 0, 0, 0, 0, 0};
      set_cfg(1);
      arm_up();
      fire_match(m);
      step(5);
      chk("t7_trigger_mid", int'(O_trigger), 1);
      reset_i = 1'b1;
      step(1);
      chk("t7_rst_trigger", int'(O_trigger), 0);
      chk("t7_rst_busy",    int'(O_busy), 0);
      reset_i = 1'b0;
      step(8);
      drain("t7");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
